aes_key_expansion: RTL and testbench

Sequential AES-128 key schedule generator that sits directly upstream of the AddRound_Key stage. It accepts one 128-bit cipher key and emits the 11 round keys (rounds 0..10) one at a time on a valid/ready stream. The AddRound_Key stage consumes each key as its `roundKey` operand. One round key is computed per accepted transfer, so no 1408-bit expanded-key store is needed.

---
 rtl/aes_key_expansion.sv | 143 ++++++++++++++
 tb/tb_aes_key_expansion.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: loads a cipher key and streams round keys 0..10 over
// a valid/ready handshake, computing one round key per accepted transfer.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module aes_key_expansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         idle,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);
    if (NR != 10) begin : g_bad_nr
        $error("aes_key_expansion only supports NR = 10 (AES-128)");
    end

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   round_key_q, round_key_d;
    logic [3:0]     round_idx_q, round_idx_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           done_q, done_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3, sub_w3, t_word;
    logic [127:0]   next_key;

    assign {w0, w1, w2, w3} = round_key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*i +: 8]),
            .out_byte (sub_w3[8*i +: 8])
        );
    end

    // Each new word chains off the one just produced, so the XORs ripple w0'..w3'.
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        t_word   = sub_w3 ^ {rcon_q, 24'h0};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    round_key_d = key;
                    round_idx_d = 4'd0;
                    rcon_d      = 8'h01;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rk_ready) begin
                    if (round_idx_q == 4'(NR)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_key_d = next_key;
                        round_idx_d = round_idx_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make all flops update together at the edge.
    // NOTE: the key register is reset too, so nothing stale is visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            rcon_q      <= 8'h01;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    assign idle      = (state_q == ST_IDLE);
    assign rk_valid  = (state_q == ST_RUN);
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: scoreboard of round keys from an
// independent key-schedule model plus FIPS-197 anchor vectors.

module tb_aes_key_expansion;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         rk_ready = 1'b0;
    logic         idle, rk_valid, done;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    always #5 clk = ~clk;

    aes_key_expansion #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .idle      (idle),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .done      (done)
    );

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] MSG    = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] rk;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb_q[$];
    vec_t         vecs[7];
    logic [7:0]   sbox_m [256];
    logic [127:0] got_rk [11];
    int           done_cnt = 0;
    bit           prev_stall = 0;
    bit           prev_xfer10 = 0;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic push_expected(input logic [127:0] k);
        logic [127:0] cur;
        logic [7:0]   rc;
        logic [31:0]  t;
        exp_t         e;
        cur = k; rc = 8'h01;
        for (int r = 0; r <= 10; r++) begin
            e.idx = 4'(r);
            e.rk  = cur;
            sb_q.push_back(e);
            t = {sbox_m[cur[23:16]], sbox_m[cur[15:8]], sbox_m[cur[7:0]], sbox_m[cur[31:24]]} ^ {rc, 24'h0};
            cur[127:96] = cur[127:96] ^ t;
            cur[95:64]  = cur[95:64] ^ cur[127:96];
            cur[63:32]  = cur[63:32] ^ cur[95:64];
            cur[31:0]   = cur[31:0] ^ cur[63:32];
            rc = gmul(rc, 8'h02);
        end
    endtask

    // Monitor: scoreboard, AddRoundKey consumer, stall stability, done placement.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall  = 0;
            prev_xfer10 = 0;
        end else begin
            if (rk_valid && prev_stall) begin
                check("stall_key_hold", round_key, prev_key);
                check("stall_idx_hold", 128'(round_idx), 128'(prev_idx));
            end
            if (done) begin
                done_cnt++;
                check("done_after_r10_xfer", 128'(prev_xfer10), 128'(1));
                check("done_rk_valid_low", 128'(rk_valid), 128'(0));
                check("done_idle_high", 128'(idle), 128'(1));
            end
            prev_xfer10 = 0;
            if (rk_valid && rk_ready) begin
                check("sb_has_expected", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_round_idx", 128'(round_idx), 128'(e.idx));
                    check("sb_round_key", round_key, e.rk);
                    check("add_round_key", MSG ^ round_key, MSG ^ e.rk);
                end
                got_rk[round_idx] = round_key;
                prev_xfer10 = (round_idx == 4'd10);
            end
            prev_stall = rk_valid && !rk_ready;
            prev_key   = round_key;
            prev_idx   = round_idx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [127:0] k);
        int budget = 0;
        while (!idle && budget < 50) begin
            tick();
            budget++;
        end
        check("idle_before_start", 128'(idle), 128'(1));
        start = 1'b1;
        key   = k;
        push_expected(k);
        tick();
        start = 1'b0;
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("latency_rk_valid", 128'(rk_valid), 128'(1));
        check("latency_round_idx", 128'(round_idx), 128'(0));
    endtask

    // Drives until the done cycle is reached; leaves the bench inside that cycle.
    task automatic finish_run(input bit rand_ready, input bit spam_start, input string tag);
        int budget = 0;
        bit stalled10 = 0;
        while (!done && budget < 400) begin
            if (rand_ready && rk_valid && round_idx == 4'd10 && !stalled10) begin
                stalled10 = 1;
                rk_ready  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check({tag, "_r10_stall_no_done"}, 128'(done), 128'(0));
                end
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = spam_start && !idle;
            if (start) key = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            budget++;
        end
        start = 1'b0;
        check({tag, "_done_reached"}, 128'(done), 128'(1));
    endtask

    task automatic settle_and_verify(input logic [127:0] k, input int base, input int runs, input string tag);
        rk_ready = 1'b1;
        start    = 1'b0;
        repeat (3) tick();
        check({tag, "_done_count"}, 128'(done_cnt), 128'(base + runs));
        check({tag, "_sb_empty"}, 128'(sb_q.size()), 128'(0));
        for (int i = 0; i < 7; i++)
            if (vecs[i].key == k)
                check($sformatf("%s_vec_r%0d", tag, vecs[i].rnd), got_rk[vecs[i].rnd], vecs[i].rk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int budget;

        vecs[0] = '{KEY_A1, 0,  KEY_A1};
        vecs[1] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KEY_A1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{128'h0, 0,  128'h0};
        vecs[5] = '{128'h0, 1,  128'h62636363626363636263636362636363};
        vecs[6] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        build_sbox();

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check("reset_idle", 128'(idle), 128'(1));
        check("reset_rk_valid", 128'(rk_valid), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_round_key", round_key, 128'h0);
        check("reset_round_idx", 128'(round_idx), 128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 A.1 with rk_ready held high: exact cycle timing.
        base = done_cnt;
        rk_ready = 1'b1;
        start_run(KEY_A1);
        repeat (10) tick();
        check("a1_r10_presented", 128'(round_idx), 128'(10));
        check("a1_no_early_done", 128'(done), 128'(0));
        tick();
        check("a1_done_cycle", 128'(done), 128'(1));
        check("a1_done_rk_valid", 128'(rk_valid), 128'(0));
        check("a1_done_idx_held", 128'(round_idx), 128'(10));
        settle_and_verify(KEY_A1, base, 1, "a1");

        // Random rk_ready stalls, including a forced stall on round 10.
        base = done_cnt;
        start_run(KEY_A1);
        finish_run(1'b1, 1'b0, "stall");
        settle_and_verify(KEY_A1, base, 1, "stall");

        // start with foreign keys during RUN, then start in the done cycle with key 0.
        base = done_cnt;
        start_run(KEY_A1);
        finish_run(1'b0, 1'b1, "spam");
        start_run(128'h0);
        finish_run(1'b0, 1'b0, "zero");
        settle_and_verify(128'h0, base, 2, "zero");

        // Reset while round 5 is presented.
        base = done_cnt;
        start_run(KEY_A1);
        budget = 0;
        while (round_idx != 4'd5 && budget < 50) begin
            tick();
            budget++;
        end
        check("rst_reached_r5", 128'(round_idx), 128'(5));
        rst_n = 1'b0;
        sb_q.delete();
        #2;
        check("rst_mid_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_mid_round_idx", 128'(round_idx), 128'(0));
        check("rst_mid_round_key", round_key, 128'h0);
        check("rst_mid_idle", 128'(idle), 128'(1));
        check("rst_mid_done", 128'(done), 128'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_key", 128'(rk_valid), 128'(0));
        end
        check("post_rst_no_done", 128'(done_cnt), 128'(base));
        base = done_cnt;
        start_run(KEY_A1);
        finish_run(1'b1, 1'b0, "post_rst");
        settle_and_verify(KEY_A1, base, 1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
